// File: rtl/decoder_2to4_buf.sv
// decoder_2to4_buf
// Registered 2-to-4 binary-to-one-hot decoder with a valid/ready handshake on
// both sides. A 2-entry skid buffer sits between the two sides. The head entry
// is the one-hot output register and the second entry is the skid register.
// With this structure in_ready comes only from a flop, and the block still
// sustains one code per cycle.
//
// state | meaning
// ------+----------------------------------------------------------
// EMPTY | nothing held; out_valid=0, in_ready=1
// ONE   | head (output) register holds a word; out_valid=1, in_ready=1
// TWO   | head and skid both hold words; out_valid=1, in_ready=0

module decoder_2to4_buf #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               x1,
    input  logic               x2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               d0,
    output logic               d1,
    output logic               d2,
    output logic               d3,
    output logic [COUNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  head_q;      // one-hot {d3,d2,d1,d0}; all zero while empty
    logic [1:0]  skid_code;   // second entry, kept as a code until promoted
    logic        push;
    logic        pop;
    logic [1:0]  in_code;

    function automatic logic [3:0] decode(input logic [1:0] code);
        decode = 4'b0001 << code;
    endfunction

    assign in_code = {x1, x2};
    assign push    = in_valid & in_ready;
    assign pop     = out_valid & out_ready;

    assign {d3, d2, d1, d0} = head_q;

    // Occupancy FSM. It also updates the head/skid registers and the
    // registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head_q    <= 4'b0000;
            skid_code <= 2'b00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q    <= decode(in_code);
                        state     <= ONE;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= decode(in_code);
                    end else if (push) begin
                        skid_code <= in_code;
                        state     <= TWO;
                        in_ready  <= 1'b0;
                    end else if (pop) begin
                        head_q    <= 4'b0000;
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move the state
                    if (pop) begin
                        head_q   <= decode(skid_code);
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    head_q    <= 4'b0000;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Delivered-word counter; it wraps silently at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
